bp_update_queue: RTL

Buffers resolved branch outcomes arriving from commit and drains them, one per handshake, into the fetch-stage pattern history table as per-counter `valid`/`update` writes for the two-bit saturating predictors. It also detects mispredictions by comparing the committed outcome with the prediction carried down the pipe. It keeps saturating statistics counters. It sits between the commit stage (producer) and the fetch-stage predictor table (consumer).

---
 rtl/bp_pkg.sv | 8 +
 rtl/bp_update_fifo.sv | 42 ++++
 rtl/bp_update_queue.sv | 51 +++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared predictor-update types for the update queue and the fetch-stage table
package bp_pkg;
  localparam int BP_IDX_W = 6;
  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                taken;
  } bp_upd_t;
endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: DEPTH-entry valid/ready queue; ports: clk, reset_n, wr_valid/wr_ready/wr_data in, rd_valid/rd_ready/rd_data out
module bp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  // ready/valid come from the registered count only, so neither side sees the other combinationally
  assign wr_ready = count != FULL_CNT;
  assign rd_valid = count != '0;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_ready && rd_valid;
  assign rd_data  = mem[rd_ptr];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/bp_update_queue.sv
// bp_update_queue: buffers committed branch outcomes into predictor-table updates; ports: commit_* in, upd_* out, mispredict pulse, saturating branch/mispredict counters
module bp_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BP_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic [31:0]      commit_pc,
  input  logic             commit_taken,
  input  logic             commit_pred,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  logic [IDX_W:0] head;
  logic           push, miss;
  logic           unused_pc;
  assign unused_pc = ^{commit_pc[31:IDX_W+2], commit_pc[1:0]};
  bp_update_fifo #(.DEPTH(DEPTH), .W(IDX_W + 1)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (commit_valid),
    .wr_ready (commit_ready),
    .wr_data  ({commit_pc[IDX_W+1:2], commit_taken}),
    .rd_valid (upd_valid),
    .rd_ready (upd_ready),
    .rd_data  (head)
  );
  assign {upd_idx, upd_taken} = head;
  assign push = commit_valid && commit_ready;
  assign miss = push && (commit_taken != commit_pred);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= miss;
      if (push && !(&branch_cnt)) branch_cnt <= branch_cnt + 1'b1;
      if (miss && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + 1'b1;
    end
endmodule
